traffic_sensor_conditioner: RTL



---
 rtl/traffic_sensor_conditioner_pkg.sv | 28 ++
 rtl/traffic_sensor_conditioner_sensor_channel.sv | 183 ++++++++++++++++++
 rtl/traffic_sensor_conditioner.sv | 84 ++++++++
 3 files changed

// File: rtl/traffic_sensor_conditioner_pkg.sv
// traffic_sensor_pkg
//   Shared types and helpers for traffic_sensor_conditioner.
//   chan_state_t : per-channel detector state encoding.
//   cnt_width()  : tick-counter width large enough for every tick limit.
package traffic_sensor_pkg;

   typedef enum logic [2:0] {
      ABSENT  = 3'd0,
      QUAL    = 3'd1,
      PRESENT = 3'd2,
      HOLD    = 3'd3,
      FAULT   = 3'd4
   } chan_state_t;

   // $clog2 of the largest limit plus one spare bit, so the terminal
   // value is always representable and the saturation guard never
   // coincides with a live compare value.
   function automatic int cnt_width(input int debounce_ticks,
                                    input int hold_ticks,
                                    input int stuck_ticks);
      int m;
      m = debounce_ticks;
      if (hold_ticks > m)  m = hold_ticks;
      if (stuck_ticks > m) m = stuck_ticks;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_sensor_channel.sv
// sensor_channel
//   One car-detector channel: 2-flop synchroniser, polarity normalisation,
//   debounce / hold state machine with a registered presence output.
//   Optional stuck-sensor detection under TRAFFIC_SENSOR_STUCK_DETECT_EN.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   tick       in   1-cycle time-base pulse shared with the other channel
//   sensor_raw in   asynchronous raw detector level
//   t          out  traffic present (registered)
//   fault      out  sensor stuck (0 when the feature is not built)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ABSENT  | no car; waiting for the synced sensor to go active
// QUAL    | sensor active; counting ticks to qualify the detection
// PRESENT | car qualified; t=1 while the sensor stays active
// HOLD    | sensor dropped; t held at 1 for HOLD_TICKS ticks
// FAULT   | presence too long (feature only); t=0, fault=1
module sensor_channel
   import traffic_sensor_pkg::*;
#(
   parameter int DEBOUNCE_TICKS    = 20,
   parameter int HOLD_TICKS        = 2_000,
   parameter int STUCK_TICKS       = 60_000,
   parameter int SENSOR_ACTIVE_LOW = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sensor_raw,
   output logic t,
   output logic fault
);

   localparam int CW = cnt_width(DEBOUNCE_TICKS, HOLD_TICKS, STUCK_TICKS);

   localparam logic [2:0] S_ABSENT  = ABSENT;
   localparam logic [2:0] S_QUAL    = QUAL;
   localparam logic [2:0] S_PRESENT = PRESENT;
   localparam logic [2:0] S_HOLD    = HOLD;
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
   localparam logic [2:0] S_FAULT   = FAULT;
   localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_TICKS - 1);
`endif

   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   localparam logic INACTIVE = (SENSOR_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic sync1_q;
   logic sync2_q;
   logic act;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= INACTIVE;
         sync2_q <= INACTIVE;
      end else begin
         sync1_q <= sensor_raw;
         sync2_q <= sync1_q;
      end
   end

   // Differs from the idle level -> a car is seen, whatever the polarity.
   assign act = sync2_q ^ INACTIVE;

   logic [2:0]    state_q;
   logic [2:0]    state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
   logic [CW-1:0] pres_q;
   logic [CW-1:0] pres_d;
   logic          fault_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
      pres_d  = pres_q;
`endif
      case (state_q)
         S_ABSENT: begin
            if (act) begin
               state_d = S_QUAL;
               cnt_d   = '0;
            end
         end
         S_QUAL: begin
            // Losing the sensor wins over a same-cycle tick.
            if (!act) begin
               state_d = S_ABSENT;
            end else if (tick) begin
               if (cnt_q == DEB_LAST) begin
                  state_d = S_PRESENT;
                  cnt_d   = '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_PRESENT: begin
            if (!act) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
            else if (tick) begin
               if (pres_q == STUCK_LAST) begin
                  state_d = S_FAULT;
               end else if (pres_q != CNT_MAX) begin
                  pres_d = pres_q + 1'b1;
               end
            end
`endif
         end
         S_HOLD: begin
            // A returning car wins over the final hold tick.
            if (act) begin
               state_d = S_PRESENT;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == HOLD_LAST) begin
                  state_d = S_ABSENT;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
         S_FAULT: begin
            if (tick && !act) begin
               state_d = S_ABSENT;
            end
         end
`endif
         default: begin
            state_d = S_ABSENT;
            cnt_d   = '0;
         end
      endcase
`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
      // Presence time only accumulates inside one uninterrupted PRESENT stay.
      if (state_d != S_PRESENT) begin
         pres_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_ABSENT;
         cnt_q   <= '0;
         t       <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t       <= (state_d == S_PRESENT) || (state_d == S_HOLD);
      end
   end

`ifdef TRAFFIC_SENSOR_STUCK_DETECT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pres_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         pres_q  <= pres_d;
         fault_q <= (state_d == S_FAULT);
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
//   Turns two raw, bouncy car-detector inputs into clean Ta/Tb presence
//   levels for the intersection controller. Holds the shared tick divider
//   and one sensor_channel per direction.
//   Build option: define TRAFFIC_SENSOR_STUCK_DETECT_EN to enable stuck
//   sensor detection (fault_a/fault_b); otherwise those outputs are 0.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   sensor_a_raw  in   asynchronous detector, direction A
//   sensor_b_raw  in   asynchronous detector, direction B
//   Ta            out  traffic present on A
//   Tb            out  traffic present on B
//   fault_a       out  A sensor stuck
//   fault_b       out  B sensor stuck
module traffic_sensor_conditioner
   import traffic_sensor_pkg::*;
#(
   parameter int CLK_HZ            = 12_000_000,
   parameter int TICK_HZ           = 1_000,
   parameter int DEBOUNCE_TICKS    = 20,
   parameter int HOLD_TICKS        = 2_000,
   parameter int STUCK_TICKS       = 60_000,
   parameter int SENSOR_ACTIVE_LOW = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor_a_raw,
   input  logic sensor_b_raw,
   output logic Ta,
   output logic Tb,
   output logic fault_a,
   output logic fault_b
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int DW  = $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [DW-1:0] div_q;
   logic          tick;

   assign tick = (div_q == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   sensor_channel #(
      .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
      .HOLD_TICKS        (HOLD_TICKS),
      .STUCK_TICKS       (STUCK_TICKS),
      .SENSOR_ACTIVE_LOW (SENSOR_ACTIVE_LOW)
   ) u_chan_a (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .sensor_raw (sensor_a_raw),
      .t          (Ta),
      .fault      (fault_a)
   );

   sensor_channel #(
      .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
      .HOLD_TICKS        (HOLD_TICKS),
      .STUCK_TICKS       (STUCK_TICKS),
      .SENSOR_ACTIVE_LOW (SENSOR_ACTIVE_LOW)
   ) u_chan_b (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .sensor_raw (sensor_b_raw),
      .t          (Tb),
      .fault      (fault_b)
   );

endmodule
